// File: rtl/l1_cache_pkg.sv
// Shared types and helpers for the two-way set-associative L1 cache.
// Geometry is fixed: 32-byte lines, 8 sets, 24-bit tags.
package cache_types;

  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int S_TAG    = 32 - S_INDEX - S_OFFSET;
  localparam int S_LINE   = 256;
  localparam int NUM_SETS = 1 << S_INDEX;

  typedef logic [S_TAG-1:0]   tag_t;
  typedef logic [S_INDEX-1:0] index_t;
  typedef logic [S_LINE-1:0]  line_t;

  typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} cache_state_t;

  // Replace only the byte lanes selected by be.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) result[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/l1_cache_way.sv
// Storage for one way: valid/dirty flags, tags and line data.
// Reads are combinational by index so hits resolve in the request cycle.
module cache_way
  import cache_types::*;
(
  input  logic   clk,
  input  logic   rst,
  input  index_t index,
  input  logic   we,
  input  logic   wr_dirty,
  input  tag_t   wr_tag,
  input  line_t  wr_line,
  output logic   valid,
  output logic   dirty,
  output tag_t   tag,
  output line_t  line
);

  logic [NUM_SETS-1:0] valid_reg;
  logic [NUM_SETS-1:0] dirty_reg;
  tag_t                tag_mem  [NUM_SETS];
  line_t               data_mem [NUM_SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (we) begin
      valid_reg[index] <= 1'b1;
      dirty_reg[index] <= wr_dirty;
    end
  end

  // Tag and data arrays are left uninitialised; valid gates their use.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[index]  <= wr_tag;
      data_mem[index] <= wr_line;
    end
  end

  assign valid = valid_reg[index];
  assign dirty = dirty_reg[index];
  assign tag   = tag_mem[index];
  assign line  = data_mem[index];

endmodule

// File: rtl/l1_cache.sv
// Two-way set-associative write-back, write-allocate L1 cache.
// Hits complete in the request cycle; misses evict/fill whole lines over pmem.
module l1_cache
  import cache_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic        pmem_resp
);

  cache_state_t        state_reg, state_next;
  logic [NUM_SETS-1:0] lru_reg;
  logic                victim_reg, victim_next;

  tag_t       req_tag;
  index_t     req_index;
  logic [2:0] req_word;
  logic       req, hit, hit_way, miss_start, wr_dirty;
  logic [1:0] way_valid, way_dirty, way_hit, way_we;
  tag_t       way_tag  [2];
  line_t      way_line [2];
  line_t      hit_line, merged_line, wr_line;
  logic [31:0] hit_word;
  logic       unused_addr_bits;

  assign req_tag          = mem_address[31:S_INDEX+S_OFFSET];
  assign req_index        = mem_address[S_INDEX+S_OFFSET-1:S_OFFSET];
  assign req_word         = mem_address[S_OFFSET-1:2];
  assign unused_addr_bits = ^mem_address[1:0];
  assign req              = mem_read | mem_write;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      assign way_hit[gi] = way_valid[gi] && (way_tag[gi] == req_tag);
      // rst masks writes so an aborted fill never lands in the arrays.
      assign way_we[gi]  = !rst &&
          (((state_reg == CHECK) && req && mem_write && hit && (hit_way == 1'(gi))) ||
           ((state_reg == ALLOCATE) && pmem_resp && (victim_reg == 1'(gi))));

      cache_way u_way (
        .clk      (clk),
        .rst      (rst),
        .index    (req_index),
        .we       (way_we[gi]),
        .wr_dirty (wr_dirty),
        .wr_tag   (req_tag),
        .wr_line  (wr_line),
        .valid    (way_valid[gi]),
        .dirty    (way_dirty[gi]),
        .tag      (way_tag[gi]),
        .line     (way_line[gi])
      );
    end
  endgenerate

  assign hit        = |way_hit;
  assign hit_way    = !way_hit[0];
  assign hit_line   = way_line[hit_way];
  assign hit_word   = hit_line[{req_word, 5'b00000} +: 32];
  assign miss_start = (state_reg == CHECK) && req && !hit;
  assign wr_dirty   = (state_reg == CHECK);
  assign wr_line    = (state_reg == ALLOCATE) ? pmem_rdata : merged_line;

  always_comb begin
    merged_line = hit_line;
    merged_line[{req_word, 5'b00000} +: 32] = merge_word(hit_word, mem_wdata, mem_byte_enable);
  end

  always_comb begin
    if (!way_valid[0])      victim_next = 1'b0;
    else if (!way_valid[1]) victim_next = 1'b1;
    else                    victim_next = lru_reg[req_index];
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= CHECK;
    else     state_reg <= state_next;
  end

  // Victim is frozen at the miss so the transfer address/data cannot shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      lru_reg    <= '0;
      victim_reg <= 1'b0;
    end else begin
      if (miss_start) victim_reg <= victim_next;
      if ((state_reg == CHECK) && req && hit) lru_reg[req_index] <= !hit_way;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CHECK:     if (miss_start)
                   state_next = (way_valid[victim_next] && way_dirty[victim_next]) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (pmem_resp) state_next = ALLOCATE;
      ALLOCATE:  if (pmem_resp) state_next = CHECK;
      default:   state_next = CHECK;
    endcase
  end

  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_reg)
      CHECK: if (req) begin
        mem_resp  = hit;
        mem_rdata = hit_word;
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {way_tag[victim_reg], req_index, {S_OFFSET{1'b0}}};
        pmem_wdata   = way_line[victim_reg];
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_index, {S_OFFSET{1'b0}}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache: per-set MRU-ordered line lists plus a
// backing memory predict every pmem transfer and every read response.
module tb_l1_cache;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address, mem_wdata, mem_rdata;
  logic         mem_resp;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;

  always #5 clk = ~clk;

  l1_cache dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Backing memory, keyed by line number; untouched lines follow a pattern.
  logic [255:0] phys [int];

  function automatic logic [255:0] phys_line(input logic [31:0] a);
    int la;
    logic [255:0] r;
    la = int'(a >> 5);
    if (phys.exists(la)) return phys[la];
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = 32'h5A00_0000 + 32'(la << 8) + 32'(w);
    return r;
  endfunction

  // Cache model: per set, up to two lines ordered most- to least-recently used.
  logic [23:0]  m_tag   [8][2];
  logic [255:0] m_data  [8][2];
  bit           m_dirty [8][2];
  int           m_cnt   [8];

  bit           exp_hit, exp_wb, exp_fill, exp_is_read;
  logic [31:0]  exp_wb_addr, exp_fill_addr, exp_rdata;
  logic [255:0] exp_wb_data;
  bit           req_active, saw_wb, saw_fill;
  logic [31:0]  last_rdata, last_wb_addr, last_fill_addr;
  logic [255:0] last_wb_data;
  int           last_lat;

  task automatic model_reset();
    for (int s = 0; s < 8; s++) m_cnt[s] = 0;
  endtask

  task automatic model_access(input bit wr, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
    int s, w, pos;
    logic [23:0] t;
    logic [255:0] line;
    bit d;
    s = int'(addr[7:5]);
    w = int'(addr[4:2]);
    t = addr[31:8];
    pos = -1;
    for (int p = 0; p < m_cnt[s]; p++) if (m_tag[s][p] == t) pos = p;
    exp_hit = (pos >= 0);
    exp_wb = 0;
    exp_fill = 0;
    if (pos >= 0) begin
      line = m_data[s][pos];
      d = m_dirty[s][pos];
      for (int p = pos; p < m_cnt[s] - 1; p++) begin
        m_tag[s][p] = m_tag[s][p+1];
        m_data[s][p] = m_data[s][p+1];
        m_dirty[s][p] = m_dirty[s][p+1];
      end
      m_cnt[s]--;
    end else begin
      if (m_cnt[s] == 2) begin
        if (m_dirty[s][1]) begin
          exp_wb = 1;
          exp_wb_addr = {m_tag[s][1], addr[7:5], 5'b0};
          exp_wb_data = m_data[s][1];
        end
        m_cnt[s] = 1;
      end
      exp_fill = 1;
      exp_fill_addr = {t, addr[7:5], 5'b0};
      line = phys_line(exp_fill_addr);
      d = 0;
    end
    if (wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) line[w*32 + b*8 +: 8] = wdata[b*8 +: 8];
      d = 1;
    end
    exp_rdata = line[w*32 +: 32];
    exp_is_read = !wr;
    for (int p = m_cnt[s]; p > 0; p--) begin
      m_tag[s][p] = m_tag[s][p-1];
      m_data[s][p] = m_data[s][p-1];
      m_dirty[s][p] = m_dirty[s][p-1];
    end
    m_tag[s][0] = t;
    m_data[s][0] = line;
    m_dirty[s][0] = d;
    m_cnt[s]++;
  endtask

  // Physical memory: answers any strobe after LAT cycles with a one-cycle resp.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (pmem_read || pmem_write) begin
        wait_cnt++;
        if (wait_cnt == LAT) begin
          pmem_resp = 1'b1;
          if (pmem_write) phys[int'(pmem_address >> 5)] = pmem_wdata;
          else            pmem_rdata = phys_line(pmem_address);
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Compare process: every meaningful output, every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (pmem_write) begin
        saw_wb = 1;
        check32("wb_expected", 32'(exp_wb), 32'd1);
        check32("wb_addr", pmem_address, exp_wb_addr);
        check256("wb_data", pmem_wdata, exp_wb_data);
        last_wb_addr = pmem_address;
        last_wb_data = pmem_wdata;
      end
      if (pmem_read) begin
        saw_fill = 1;
        check32("fill_addr", pmem_address, exp_fill_addr);
        last_fill_addr = pmem_address;
      end
      if (pmem_read && pmem_write) check32("pmem_both", 32'(pmem_write), 32'd0);
      if (mem_resp) begin
        check32("resp_unrequested", 32'(req_active), 32'd1);
        if (exp_is_read) check32("rdata", mem_rdata, exp_rdata);
      end
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int cyc;
    bit got;
    model_access(wr, be, addr, wdata);
    saw_wb = 0;
    saw_fill = 0;
    @(posedge clk); #1;
    mem_read = rd;
    mem_write = wr;
    mem_byte_enable = be;
    mem_address = addr;
    mem_wdata = wdata;
    req_active = 1;
    cyc = 0;
    got = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (mem_resp) begin
        got = 1;
        last_rdata = mem_rdata;
      end else begin
        cyc++;
      end
    end
    check32("resp_timeout", 32'(got), 32'd1);
    last_lat = cyc;
    if (exp_hit) check32("hit_latency", 32'(cyc), 32'd0);
    check32("wb_seen", 32'(saw_wb), 32'(exp_wb));
    check32("fill_seen", 32'(saw_fill), 32'(exp_fill));
    $display("txn rd=%0d wr=%0d be=%h addr=%h wdata=%h lat=%0d rdata=%h wb=%0d fill=%0d",
             rd, wr, be, addr, wdata, cyc, last_rdata, saw_wb, saw_fill);
    @(posedge clk); #1;
    mem_read = 0;
    mem_write = 0;
    req_active = 0;
  endtask

  bit          tab_rd [6] = '{1, 0, 1, 1, 1, 1};
  bit          tab_wr [6] = '{0, 1, 0, 0, 0, 0};
  logic [3:0]  tab_be [6] = '{4'h0, 4'b1100, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [31:0] tab_addr [6] = '{32'h0A0, 32'h1A4, 32'h1A4, 32'h2A8, 32'h0AC, 32'h1A4};
  logic [31:0] tab_wdata [6] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h0};

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [255:0] seed_line;
    bit got;
    for (int w = 0; w < 8; w++) seed_line[w*32 +: 32] = 32'h0000_1000 + 32'(w);
    seed_line[31:0]  = 32'hDEADBEEF;
    seed_line[63:32] = 32'hAABBCCDD;
    phys[2] = seed_line;

    rst = 1; mem_read = 0; mem_write = 0; mem_byte_enable = 0;
    mem_address = 0; mem_wdata = 0; req_active = 0;
    saw_wb = 0; saw_fill = 0;
    exp_hit = 0; exp_wb = 0; exp_fill = 0; exp_is_read = 0;
    exp_wb_addr = 0; exp_fill_addr = 0; exp_rdata = 0; exp_wb_data = 0;
    last_rdata = 0; last_wb_addr = 0; last_fill_addr = 0; last_wb_data = 0; last_lat = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check32("reset_mem_resp", 32'(mem_resp), 32'd0);
    check32("reset_pmem_read", 32'(pmem_read), 32'd0);
    check32("reset_pmem_write", 32'(pmem_write), 32'd0);
    check32("reset_pmem_address", pmem_address, 32'd0);
    check32("reset_mem_rdata", mem_rdata, 32'd0);

    access(1, 0, 4'h0, 32'h040, 32'h0);
    check32("cold_rdata", last_rdata, 32'hDEADBEEF);
    check32("cold_fill_addr", last_fill_addr, 32'h040);
    check32("cold_latency", 32'(last_lat), 32'd3);
    access(1, 0, 4'h0, 32'h040, 32'h0);
    check32("rehit_latency", 32'(last_lat), 32'd0);
    access(0, 1, 4'b0101, 32'h044, 32'h11223344);
    access(1, 0, 4'h0, 32'h044, 32'h0);
    check32("merge_rdata", last_rdata, 32'hAA22CC44);

    access(1, 0, 4'h0, 32'h140, 32'h0);
    access(1, 0, 4'h0, 32'h040, 32'h0);
    access(1, 0, 4'h0, 32'h240, 32'h0);
    check32("lru_fill_addr", last_fill_addr, 32'h240);
    access(1, 0, 4'h0, 32'h140, 32'h0);
    check32("dirty_wb_addr", last_wb_addr, 32'h040);
    check32("dirty_wb_word1", last_wb_data[63:32], 32'hAA22CC44);
    check32("dirty_fill_addr", last_fill_addr, 32'h140);
    check32("dirty_latency", 32'(last_lat), 32'd5);
    access(1, 0, 4'h0, 32'h044, 32'h0);
    check32("refetch_rdata", last_rdata, 32'hAA22CC44);

    access(1, 1, 4'hF, 32'h048, 32'h5);
    access(1, 0, 4'h0, 32'h048, 32'h0);
    check32("rdwr_rdata", last_rdata, 32'h5);
    access(1, 0, 4'h0, 32'h240, 32'h0);
    access(1, 0, 4'h0, 32'h140, 32'h0);
    check32("rdwr_wb_addr", last_wb_addr, 32'h040);
    check32("rdwr_wb_word2", last_wb_data[95:64], 32'h5);

    for (int i = 0; i < 6; i++) access(tab_rd[i], tab_wr[i], tab_be[i], tab_addr[i], tab_wdata[i]);
    check32("set5_rdata", last_rdata, 32'hCAFE0000 | (32'h5A00_0000 + 32'(13 << 8) + 32'd1) & 32'h0000FFFF);

    // Reset in the middle of a fill, coinciding with the pmem response.
    model_access(0, 4'h0, 32'h300, 32'h0);
    saw_fill = 0;
    @(posedge clk); #1;
    mem_read = 1; mem_address = 32'h300; req_active = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = pmem_read;
    end
    check32("rst_alloc_reached", 32'(got), 32'd1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; mem_read = 0; req_active = 0;
    @(negedge clk);
    check32("rst_pmem_read", 32'(pmem_read), 32'd0);
    check32("rst_pmem_write", 32'(pmem_write), 32'd0);
    model_reset();
    $display("txn reset during allocate addr=00000300");
    access(1, 0, 4'h0, 32'h300, 32'h0);
    check32("rst_refill_latency", 32'(last_lat), 32'd3);
    access(1, 0, 4'h0, 32'h140, 32'h0);
    check32("rst_cleared_latency", 32'(last_lat), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
